// File: rtl/zigzag_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : zigzag_scanner
//  Description : Double-banked 8x8 block capture with zigzag-order streaming
//                readout over a valid/ready interface. Blocks arriving while
//                both banks are full are dropped and flagged in a sticky
//                overflow bit.
//                Optional macro ZIGZAG_EOB_TRUNC_EN: end the stream of each
//                block at its last nonzero coefficient in zigzag order.
//  Revision    : 1.0 - initial release
// ============================================================================
module zigzag_scanner #(
  parameter int DATA_W = 11
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_enable,
  input  logic signed [DATA_W-1:0] in_block [8][8],
  output logic                     in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic [5:0]               out_index,
  output logic                     out_first,
  output logic                     out_last,
  output logic                     overflow
);

  // Zigzag index -> natural position {row[2:0], col[2:0]}
  localparam logic [5:0] ZZ [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t state;
  state_t state_nx;

  logic signed [DATA_W-1:0] bank_a [8][8];
  logic signed [DATA_W-1:0] bank_b [8][8];

  logic                     full_a;
  logic                     full_b;
  logic                     rd_sel;      // bank being drained: 0 = A, 1 = B
  logic                     ovf;
  logic [5:0]               idx;
  logic [5:0]               idx_nx;
  logic [5:0]               last_idx;
  logic [5:0]               zz_pos;
  logic                     capture;
  logic                     wr_sel;
  logic                     accept;
  logic                     last_beat;
  logic                     other_full;
  logic signed [DATA_W-1:0] rd_word;

  // A is written whenever it is empty, so A wins when both are empty.
  assign in_ready   = ~full_a | ~full_b;
  assign capture    = in_enable & in_ready;
  assign wr_sel     = full_a;
  assign out_valid  = (state == STREAM);
  assign accept     = out_valid & out_ready;
  assign last_beat  = accept & (idx == last_idx);
  assign other_full = rd_sel ? full_a : full_b;

`ifdef ZIGZAG_EOB_TRUNC_EN
  logic [5:0] eob_a;
  logic [5:0] eob_b;
  logic [5:0] eob_in;

  // Position of the last nonzero coefficient of the incoming block, zigzag order
  always_comb begin
    eob_in = '0;
    for (int k = 0; k < 64; k++) begin
      if (in_block[ZZ[k[5:0]][5:3]][ZZ[k[5:0]][2:0]] != '0) eob_in = k[5:0];
    end
  end

  // Per-bank end-of-block position, stored alongside the captured data
  always_ff @(posedge clk) begin
    if (rst) begin
      eob_a <= '0;
      eob_b <= '0;
    end else if (capture) begin
      if (wr_sel) eob_b <= eob_in;
      else        eob_a <= eob_in;
    end
  end

  assign last_idx = rd_sel ? eob_b : eob_a;
`else
  assign last_idx = 6'd63;
`endif

  // Coefficient storage; contents are only observed while the bank is FULL
  always_ff @(posedge clk) begin
    if (capture && !wr_sel) bank_a <= in_block;
    if (capture &&  wr_sel) bank_b <= in_block;
  end

  // Bank occupancy, drain order and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      full_a <= 1'b0;
      full_b <= 1'b0;
      rd_sel <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      // Release and capture always target different banks on one edge
      if (last_beat && !rd_sel) full_a <= 1'b0;
      if (last_beat &&  rd_sel) full_b <= 1'b0;
      if (capture   && !wr_sel) full_a <= 1'b1;
      if (capture   &&  wr_sel) full_b <= 1'b1;
      if (state == IDLE) begin
        if (capture) rd_sel <= wr_sel;
      end else if (last_beat) begin
        rd_sel <= ~rd_sel;
      end
      if (in_enable && !in_ready) ovf <= 1'b1;
    end
  end

  // Output FSM state and zigzag index register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
    end
  end

  // Next-state: start on capture, advance on accept, chain banks without a bubble
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    case (state)
      IDLE: begin
        if (capture || full_a || full_b) begin
          state_nx = STREAM;
          idx_nx   = '0;
        end
      end
      STREAM: begin
        if (last_beat) begin
          idx_nx = '0;
          if (!other_full && !capture) state_nx = IDLE;
        end else if (accept) begin
          idx_nx = idx + 6'd1;
        end
      end
      default: begin
        state_nx = IDLE;
        idx_nx   = '0;
      end
    endcase
  end

  // Read the current coefficient from the draining bank
  always_comb begin
    zz_pos  = ZZ[idx];
    rd_word = rd_sel ? bank_b[zz_pos[5:3]][zz_pos[2:0]]
                     : bank_a[zz_pos[5:3]][zz_pos[2:0]];
  end

  assign out_data  = out_valid ? rd_word : '0;
  assign out_index = idx;
  assign out_first = out_valid & (idx == 6'd0);
  assign out_last  = out_valid & (idx == last_idx);
  assign overflow  = ovf;

endmodule
`default_nettype wire
